// File: rtl/aes_package.sv
// Shared widths, state encodings and status flags for the AES stream gearbox.
package aes_package;

    localparam int unsigned AES_WORD_W  = 32;
    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_WORDS   = AES_BLOCK_W / AES_WORD_W;
    localparam int unsigned AES_CNT_W   = $clog2(AES_WORDS);

    typedef logic [AES_CNT_W-1:0] aes_cnt_t;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } aes_pack_state_e;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } aes_unpack_state_e;

    typedef struct packed {
        aes_cnt_t in_cnt;
        aes_cnt_t out_cnt;
        logic     blk_pending;
        logic     emitting;
        logic     strb_err;
    } aes_gearbox_flags_t;

    // Bit offset of word slot idx inside a block (word k lives at [32k+31:32k]).
    function automatic logic [AES_CNT_W+4:0] slot_lsb(input aes_cnt_t idx);
        return {idx, 5'd0};
    endfunction

endpackage

// File: rtl/aes_stream_gearbox_if.sv
// Valid/ready word stream with byte strobes, used for both gearbox stream ports.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = aes_package::AES_WORD_W
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);

endinterface

// File: rtl/aes_stream_gearbox.sv
// Packs 32-bit words into 128-bit blocks for the AES core and unpacks result
// blocks back into 32-bit words; the two directions run independently.
module aes_stream_gearbox
    import aes_package::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      test_mode_i,
    input  logic                      clear_i,
    hwpe_stream_intf_stream.sink      a_i,
    output logic [AES_BLOCK_W-1:0]    blk_data_o,
    output logic                      blk_valid_o,
    input  logic                      blk_ready_i,
    input  logic [AES_BLOCK_W-1:0]    res_data_i,
    input  logic                      res_valid_i,
    output logic                      res_ready_o,
    hwpe_stream_intf_stream.source    d_o,
    output aes_gearbox_flags_t        flags_o
);

    aes_pack_state_e         pack_state_q;
    aes_cnt_t                in_cnt_q;
    logic [AES_BLOCK_W-1:0]  blk_q;
    logic                    strb_err_q;

    aes_unpack_state_e       unpack_state_q;
    aes_cnt_t                out_cnt_q;
    logic [AES_BLOCK_W-1:0]  res_q;

    logic unused_test_mode;
    assign unused_test_mode = test_mode_i;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: the block and result registers are reset and cleared as well, so
    // no stale plaintext or ciphertext is ever visible on the outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin : pack_fsm
        if (!rst_ni) begin
            pack_state_q <= COLLECT;
            in_cnt_q     <= '0;
            blk_q        <= '0;
            strb_err_q   <= 1'b0;
        end else if (clear_i) begin
            pack_state_q <= COLLECT;
            in_cnt_q     <= '0;
            blk_q        <= '0;
            strb_err_q   <= 1'b0;
        end else begin
            unique case (pack_state_q)
                COLLECT: begin
                    if (a_i.valid) begin
                        blk_q[slot_lsb(in_cnt_q) +: AES_WORD_W] <= a_i.data;
                        in_cnt_q <= in_cnt_q + 1'b1;
                        // Partial strobes are still packed; the error is only flagged.
                        if (a_i.strb != '1) begin
                            strb_err_q <= 1'b1;
                        end
                        if (in_cnt_q == aes_cnt_t'(AES_WORDS - 1)) begin
                            pack_state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (blk_ready_i) begin
                        pack_state_q <= COLLECT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : unpack_fsm
        if (!rst_ni) begin
            unpack_state_q <= IDLE;
            out_cnt_q      <= '0;
            res_q          <= '0;
        end else if (clear_i) begin
            unpack_state_q <= IDLE;
            out_cnt_q      <= '0;
            res_q          <= '0;
        end else begin
            unique case (unpack_state_q)
                IDLE: begin
                    if (res_valid_i) begin
                        res_q          <= res_data_i;
                        out_cnt_q      <= '0;
                        unpack_state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (d_o.ready) begin
                        out_cnt_q <= out_cnt_q + 1'b1;
                        if (out_cnt_q == aes_cnt_t'(AES_WORDS - 1)) begin
                            unpack_state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Handshake outputs decode registered state directly, so they are glitch-free
    // and a released block cannot admit a new word in the same cycle.
    assign a_i.ready   = (pack_state_q == COLLECT);
    assign blk_valid_o = (pack_state_q == HOLD);
    assign blk_data_o  = blk_q;

    assign res_ready_o = (unpack_state_q == IDLE);
    assign d_o.valid   = (unpack_state_q == EMIT);
    assign d_o.data    = res_q[slot_lsb(out_cnt_q) +: AES_WORD_W];
    assign d_o.strb    = '1;

    assign flags_o.in_cnt      = in_cnt_q;
    assign flags_o.out_cnt     = out_cnt_q;
    assign flags_o.blk_pending = (pack_state_q == HOLD);
    assign flags_o.emitting    = (unpack_state_q == EMIT);
    assign flags_o.strb_err    = strb_err_q;

endmodule

// File: doc/aes_stream_gearbox.md
AES_STREAM_GEARBOX -- requirements
Module: aes_stream_gearbox

Interface
REQ-001 Parameters: none; width constants come from aes_package (AES_WORD_W=32, AES_BLOCK_W=128, AES_WORDS=4).
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 test_mode_i  input  1  DFT only; no functional effect.
REQ-005 clear_i  input  1  synchronous soft clear.
REQ-006 a_i  hwpe_stream_intf_stream.sink  32  plaintext/key word stream in.
REQ-007 blk_data_o  output  128  assembled block toward AES core.
REQ-008 blk_valid_o  output  1  block valid.
REQ-009 blk_ready_i  input  1  core accepts block.
REQ-010 res_data_i  input  128  result block from AES core.
REQ-011 res_valid_i  input  1  result valid.
REQ-012 res_ready_o  output  1  gearbox accepts result.
REQ-013 d_o  hwpe_stream_intf_stream.source  32  result word stream out.
REQ-014 flags_o  output  aes_gearbox_flags_t  {in_cnt[1:0], out_cnt[1:0], blk_pending, emitting, strb_err}.

Function
REQ-015 Pack side SHALL be a 2-state FSM: COLLECT, HOLD.
REQ-016 In COLLECT, a_i.ready SHALL be 1; each a_i handshake writes a_i.data into slot in_cnt (word k -> bits [32k+31:32k]) and increments in_cnt.
REQ-017 The handshake accepting word 3 SHALL move to HOLD; blk_valid_o SHALL be 1 the next cycle (1-cycle latency), in_cnt wraps to 0.
REQ-018 In HOLD, a_i.ready SHALL be 0; blk_data_o and blk_valid_o SHALL be stable until blk_ready_i.
REQ-019 blk_valid_o && blk_ready_i SHALL return to COLLECT; a_i.ready is 1 in the following cycle (no same-cycle bypass).
REQ-020 A handshake with a_i.strb != 4'hF SHALL still be accepted and SHALL set sticky strb_err.
REQ-021 Unpack side SHALL be a 2-state FSM: IDLE, EMIT.
REQ-022 In IDLE, res_ready_o SHALL be 1; res_valid_i captures res_data_i into the output register and moves to EMIT with out_cnt=0.
REQ-023 In EMIT, res_ready_o SHALL be 0, d_o.valid SHALL be 1, d_o.data = slot out_cnt, d_o.strb = 4'hF.
REQ-024 d_o.valid SHALL not retract before d_o.ready; each handshake increments out_cnt; handshake on word 3 returns to IDLE, out_cnt wraps to 0.
REQ-025 Pack and unpack sides SHALL operate independently and concurrently.
REQ-026 clear_i SHALL force COLLECT/IDLE, counters 0, data registers 0, strb_err 0; clear_i wins over any simultaneous handshake (data discarded).
REQ-027 flags_o.blk_pending = (HOLD); flags_o.emitting = (EMIT).

Reset
REQ-028 On rst_ni low: COLLECT, IDLE, counters 0, data registers 0, strb_err 0, asynchronously.
REQ-029 Output values in reset: a_i.ready=1, res_ready_o=1, blk_valid_o=0, d_o.valid=0, blk_data_o=0, d_o.data=0, flags_o=0.
REQ-030 Reset mid-block SHALL discard partial words; no spurious valid after release.

Structure
REQ-031 aes_package SHALL hold AES_WORD_W, AES_BLOCK_W, AES_WORDS, aes_gearbox_flags_t and the two FSM state enums.
REQ-032 No sub-module; both FSMs live in this module.

Verification
REQ-033 Words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C back-to-back, blk_ready_i=1 -> blk_valid_o one cycle after 4th, blk_data_o=0x0F0E0D0C_0B0A0908_07060504_03020100.
REQ-034 Block held with blk_ready_i=0 for 5 cycles while a_i.valid=1 -> a_i.ready=0, blk_data_o stable, no word lost after release.
REQ-035 res_data_i=0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A, d_o.ready toggling 1/0 -> words 0x70B4C55A, 0xD8CDB780, 0x6A7B0430, 0x69C4E0D8 in order, res_ready_o=1 only after 4th.
REQ-036 Word with strb=4'h7 -> accepted, in_cnt increments, strb_err=1 until clear_i.
REQ-037 clear_i asserted with in_cnt=2 and simultaneous a_i handshake -> next cycle in_cnt=0, blk_data_o=0, COLLECT.
REQ-038 rst_ni pulsed low during EMIT at out_cnt=1 -> d_o.valid=0 immediately, res_ready_o=1, flags_o=0.
